dmem_bus_arbiter: RTL and testbench
===================================

// Module: dmem_bus_arbiter
// PURPOSE
//   Shared data-memory port arbiter, downstream of each core's L1 cache subsystem.
//   Accepts miss-fill reads and write-throughs from NUM_CORES L1 controllers.
//   Serialises them round-robin onto the single data memory port.
//   Returns read data and a one-cycle completion pulse to the owning core.
// PARAMETERS
//   NUM_CORES  2   number of requesting L1 controllers (>=2)
//   ADDR_W     10  word/byte address width of data memory
//   DATA_W     32  data width
//   MEM_LAT    1   data-memory read latency in cycles (0 = combinational read)
// PORTS
//   clk        in   1                  clock, all state on posedge
//   reset      in   1                  synchronous, active-high
//   req        in   NUM_CORES          per-core request, held until done
//   req_wr     in   NUM_CORES          1 = write, 0 = read
//   req_addr   in   NUM_CORES*ADDR_W   per-core address, core i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   NUM_CORES*DATA_W   per-core write data
//   req_mask   in   NUM_CORES*3        per-core byte/half/word mask code
//   gnt        out  NUM_CORES          one-hot owner, ISSUE..DONE
//   done       out  NUM_CORES          one-cycle completion pulse to owner
//   rdata      out  DATA_W             read data, valid while done is high
//   mem_addr   out  ADDR_W             to data memory
//   mem_wdata  out  DATA_W             to data memory
//   mem_mask   out  3                  to data memory
//   mem_wr_en  out  1                  to data memory
//   mem_rd_en  out  1                  to data memory
//   mem_rdata  in   DATA_W             from data memory
// BEHAVIOUR
//   Reset values
//   - All outputs 0, state IDLE.
//   - last_owner = NUM_CORES-1, so core 0 wins first.
//   FSM states: IDLE, ISSUE, WAIT, DONE.
//   - IDLE
//     - If any req, pick the first requester after last_owner, cyclic.
//     - Latch its wr/addr/wdata/mask into holding registers.
//     - Move to ISSUE.
//   - ISSUE
//     - mem_*_en high for exactly this cycle; mem_addr/wdata/mask come from the holding regs.
//     - Write: go to DONE.
//     - Read with MEM_LAT=0: capture mem_rdata, go to DONE.
//     - Otherwise: load lat_cnt = MEM_LAT-1, go to WAIT.
//   - WAIT
//     - mem_rd_en low.
//     - On lat_cnt==0: capture mem_rdata, go to DONE; else decrement lat_cnt.
//   - DONE
//     - done[owner]=1 and rdata = captured value (write: rdata=0).
//     - last_owner <= owner; go to IDLE.
//   Latency
//   - req sampled in IDLE at edge k gives done at edge k+2 (write).
//   - Read gives done at edge k+2+MEM_LAT.
//   - Back-to-back throughput: one transaction per 3(+MEM_LAT) cycles.
//   Handshake rules
//   - Requester keeps req and its payload stable until done, then may drop or re-raise.
//   - A req still high in the DONE cycle is re-sampled in the next IDLE as a new request.
//   - A req dropped mid-transaction does not abort it; it completes and done still pulses.
//   Boundary conditions
//   - Simultaneous requests: round-robin, so no core waits more than NUM_CORES-1 transactions.
//   - Single requester repeating: granted every transaction.
//   - Reset mid-transaction: at the next edge, state IDLE and all outputs 0.
//     No done is produced; the memory write is lost only if reset coincides with ISSUE.
//   - Outputs are registered or decoded from state only; no req->gnt combinational path.
// CONFIGURATION
//   ARB_STATS_EN defined
//   - Adds output grant_cnt (NUM_CORES*16): per-core completed-transaction counter.
//   - Increments in DONE, saturates at 16'hFFFF, clears on reset.
//   ARB_STATS_EN undefined
//   - Port and counters absent; behaviour otherwise identical.
// STRUCTURE
//   Package dmem_arb_pkg
//   - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
//   - Mask code constants shared with the L1 controller and data memory.
//   Sub-module rr_priority_picker
//   - Combinational: req vector + last_owner -> one-hot pick and index.
//   - Instantiated once.
// TESTING
//   1. Reset, core0 read addr 0x010, mem holds 0xDEADBEEF, MEM_LAT=1
//      -> gnt=01 at k+1, done[0] and rdata=0xDEADBEEF at k+3.
//   2. Both cores raise req in the same cycle, both writes
//      -> core0 serviced first, core1 next; mem_wr_en pulses 2 times, never together.
//   3. Both hold req continuously for 6 transactions
//      -> grant order 0,1,0,1,0,1; each done a single cycle.
//   4. Core1 write 0x0000_00AA to 0x3FF, mask byte
//      -> mem_addr=0x3FF, mem_mask=byte, mem_wr_en exactly 1 cycle, done[1] at k+2.
//   5. Reset asserted in WAIT
//      -> next cycle all outputs 0, no done; next request serviced normally.
//   6. ARB_STATS_EN, core0 does 3 transactions
//      -> grant_cnt[0]=3, grant_cnt[1]=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory bus arbiter: FSM state encoding and the
// access-size mask codes understood by the L1 controllers and the data memory.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Access-size codes carried on req_mask / mem_mask.
  localparam logic [2:0] MASK_BYTE  = 3'b000;
  localparam logic [2:0] MASK_HALF  = 3'b001;
  localparam logic [2:0] MASK_WORD  = 3'b010;
  localparam logic [2:0] MASK_BYTEU = 3'b100;
  localparam logic [2:0] MASK_HALFU = 3'b101;

  localparam int STAT_CNT_W = 16;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches the request vector starting at
// the core after last_owner and wrapping, returning the first hit.
module rr_priority_picker #(
  parameter int NUM_CORES = 2,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     last_owner,
  output logic                 pick_vld,
  output logic [NUM_CORES-1:0] pick_oh,
  output logic [IDX_W-1:0]     pick_idx
);

  logic [IDX_W-1:0] cand;

  // Offset 1 first so the previous owner is considered last.
  always_comb begin
    pick_vld = 1'b0;
    pick_oh  = '0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = IDX_W'((int'(last_owner) + i) % NUM_CORES);
      if (!pick_vld && req[cand]) begin
        pick_vld      = 1'b1;
        pick_oh[cand] = 1'b1;
        pick_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter serialising L1 miss-fills and write-throughs onto one
// data-memory port. Define ARB_STATS_EN to add per-core grant_cnt counters.
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        req_wr,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
  input  logic [NUM_CORES*3-1:0]      req_mask,
  output logic [NUM_CORES-1:0]        gnt,
  output logic [NUM_CORES-1:0]        done,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [2:0]                  mem_mask,
  output logic                        mem_wr_en,
  output logic                        mem_rd_en,
`ifdef ARB_STATS_EN
  output logic [NUM_CORES*16-1:0]     grant_cnt,
`endif
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t             state;
  logic [IDX_W-1:0]       last_owner;
  logic [IDX_W-1:0]       owner_idx;
  logic [NUM_CORES-1:0]   owner_oh;
  logic [LAT_W-1:0]       lat_cnt;

  logic                   pick_vld;
  logic [NUM_CORES-1:0]   pick_oh;
  logic [IDX_W-1:0]       pick_idx;

  logic                   sel_wr;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;
  logic [2:0]             sel_mask;

  logic                   hold_wr;
  logic [ADDR_W-1:0]      hold_addr;
  logic [DATA_W-1:0]      hold_wdata;
  logic [2:0]             hold_mask;
  logic [DATA_W-1:0]      rd_q;
  logic                   capture;

  rr_priority_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req        (req),
    .last_owner (last_owner),
    .pick_vld   (pick_vld),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pick_oh[i]) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_mask  = req_mask[i*3 +: 3];
      end
    end
  end

  // Read data is taken on the cycle the memory presents it.
  assign capture = ((state == ISSUE) && !hold_wr && (MEM_LAT == 0)) ||
                   ((state == WAIT) && (lat_cnt == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= IDX_W'(NUM_CORES - 1);
      owner_idx  <= '0;
      owner_oh   <= '0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner_idx <= pick_idx;
            owner_oh  <= pick_oh;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (hold_wr || (MEM_LAT == 0)) begin
            state <= DONE;
          end else begin
            lat_cnt <= LAT_W'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) state <= DONE;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        DONE: begin
          last_owner <= owner_idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload holding registers carry no reset; outputs are gated by state.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && pick_vld) begin
      hold_wr    <= sel_wr;
      hold_addr  <= sel_addr;
      hold_wdata <= sel_wdata;
      hold_mask  <= sel_mask;
    end
    if (capture) rd_q <= mem_rdata;
  end

  assign gnt       = (state != IDLE) ? owner_oh : '0;
  assign done      = (state == DONE) ? owner_oh : '0;
  assign rdata     = ((state == DONE) && !hold_wr) ? rd_q : '0;
  assign mem_wr_en = (state == ISSUE) && hold_wr;
  assign mem_rd_en = (state == ISSUE) && !hold_wr;
  assign mem_addr  = (state != IDLE) ? hold_addr  : '0;
  assign mem_wdata = (state != IDLE) ? hold_wdata : '0;
  assign mem_mask  = (state != IDLE) ? hold_mask  : '0;

`ifdef ARB_STATS_EN
  function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
    return (v == {STAT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [STAT_CNT_W-1:0] cnt_q [NUM_CORES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (owner_oh[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed self-checking bench for dmem_bus_arbiter with a one-cycle-latency
// behavioural data memory; grant_cnt checks are built when ARB_STATS_EN is set.
module tb_dmem_bus_arbiter;
  import dmem_arb_pkg::*;

  localparam int NUM_CORES = 2;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MEM_LAT   = 1;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_CORES-1:0]        req;
  logic [NUM_CORES-1:0]        req_wr;
  logic [NUM_CORES*ADDR_W-1:0] req_addr;
  logic [NUM_CORES*DATA_W-1:0] req_wdata;
  logic [NUM_CORES*3-1:0]      req_mask;
  logic [NUM_CORES-1:0]        gnt;
  logic [NUM_CORES-1:0]        done;
  logic [DATA_W-1:0]           rdata;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [2:0]                  mem_mask;
  logic                        mem_wr_en;
  logic                        mem_rd_en;
  logic [DATA_W-1:0]           mem_rdata;
`ifdef ARB_STATS_EN
  logic [NUM_CORES*16-1:0]     grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int wr_pulses = 0;
  int wr_base;
  logic [ADDR_W-1:0] last_wr_addr;
  logic [DATA_W-1:0] last_wr_data;

  dmem_bus_arbiter #(
    .NUM_CORES (NUM_CORES),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_wr_en (mem_wr_en),
    .mem_rd_en (mem_rd_en),
`ifdef ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
    return (a == 10'h010) ? 32'hDEAD_BEEF : {22'h0, a};
  endfunction

  // Registered-read memory: data appears the cycle after mem_rd_en.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= rd_model(mem_addr);
    if (mem_wr_en) begin
      wr_pulses    <= wr_pulses + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [2:0] m);
    req_wr[c]                    = wr;
    req_addr[c*ADDR_W +: ADDR_W] = a;
    req_wdata[c*DATA_W +: DATA_W] = d;
    req_mask[c*3 +: 3]           = m;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   64'(gnt), 64'h0);
    chk({tag, "_done"},  64'(done), 64'h0);
    chk({tag, "_rdata"}, 64'(rdata), 64'h0);
    chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'h0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'h0);
    chk({tag, "_addr"},  64'(mem_addr), 64'h0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'h0);
    chk({tag, "_mask"},  64'(mem_mask), 64'h0);
`ifdef ARB_STATS_EN
    chk({tag, "_gcnt"},  64'(grant_cnt), 64'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_mask  = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b0;

    // Core0 read of 0x010 with one cycle of memory latency
    set_req(0, 1'b0, 10'h010, 32'h0, MASK_WORD);
    req[0] = 1'b1;
    tick();
    chk("t1_issue_gnt",   64'(gnt), 64'h1);
    chk("t1_issue_rd_en", 64'(mem_rd_en), 64'h1);
    chk("t1_issue_wr_en", 64'(mem_wr_en), 64'h0);
    chk("t1_issue_addr",  64'(mem_addr), 64'h010);
    tick();
    chk("t1_wait_gnt",    64'(gnt), 64'h1);
    chk("t1_wait_rd_en",  64'(mem_rd_en), 64'h0);
    chk("t1_wait_done",   64'(done), 64'h0);
    tick();
    chk("t1_done",        64'(done), 64'h1);
    chk("t1_rdata",       64'(rdata), 64'hDEAD_BEEF);
    req[0] = 1'b0;
    tick();
    chk("t1_idle_done",   64'(done), 64'h0);
    chk("t1_idle_gnt",    64'(gnt), 64'h0);
    chk("t1_idle_rdata",  64'(rdata), 64'h0);

    // Core1 byte write to the top address
    set_req(1, 1'b1, 10'h3FF, 32'h0000_00AA, MASK_BYTE);
    req[1] = 1'b1;
    wr_base = wr_pulses;
    tick();
    chk("t4_gnt",       64'(gnt), 64'h2);
    chk("t4_addr",      64'(mem_addr), 64'h3FF);
    chk("t4_mask",      64'(mem_mask), 64'(MASK_BYTE));
    chk("t4_wdata",     64'(mem_wdata), 64'hAA);
    chk("t4_wr_en",     64'(mem_wr_en), 64'h1);
    chk("t4_rd_en",     64'(mem_rd_en), 64'h0);
    tick();
    chk("t4_done",      64'(done), 64'h2);
    chk("t4_wr_en_off", 64'(mem_wr_en), 64'h0);
    chk("t4_rdata",     64'(rdata), 64'h0);
    chk("t4_wr_count",  64'(wr_pulses - wr_base), 64'h1);
    chk("t4_mem_addr",  64'(last_wr_addr), 64'h3FF);
    chk("t4_mem_data",  64'(last_wr_data), 64'hAA);
    req[1] = 1'b0;
    tick();
    chk("t4_idle_done", 64'(done), 64'h0);

    // Simultaneous writes: core0 first (core1 was last owner), then core1
    set_req(0, 1'b1, 10'h020, 32'h1111_1111, MASK_WORD);
    set_req(1, 1'b1, 10'h021, 32'h2222_2222, MASK_HALF);
    req = 2'b11;
    wr_base = wr_pulses;
    tick();
    chk("t2_a_gnt",   64'(gnt), 64'h1);
    chk("t2_a_wr_en", 64'(mem_wr_en), 64'h1);
    chk("t2_a_addr",  64'(mem_addr), 64'h020);
    tick();
    chk("t2_a_done",  64'(done), 64'h1);
    chk("t2_a_mdata", 64'(last_wr_data), 64'h1111_1111);
    req[0] = 1'b0;
    tick();
    chk("t2_idle_gnt",   64'(gnt), 64'h0);
    chk("t2_idle_wr_en", 64'(mem_wr_en), 64'h0);
    tick();
    chk("t2_b_gnt",   64'(gnt), 64'h2);
    chk("t2_b_wr_en", 64'(mem_wr_en), 64'h1);
    chk("t2_b_addr",  64'(mem_addr), 64'h021);
    chk("t2_b_mask",  64'(mem_mask), 64'(MASK_HALF));
    tick();
    chk("t2_b_done",  64'(done), 64'h2);
    chk("t2_b_mdata", 64'(last_wr_data), 64'h2222_2222);
    req[1] = 1'b0;
    tick();
    chk("t2_wr_count", 64'(wr_pulses - wr_base), 64'h2);

    // Both cores hold req for six back-to-back writes
    set_req(0, 1'b1, 10'h030, 32'hA0A0_A0A0, MASK_WORD);
    set_req(1, 1'b1, 10'h031, 32'hB1B1_B1B1, MASK_WORD);
    req = 2'b11;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("t3_gnt", 64'(gnt), (t % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      chk("t3_done", 64'(done), (t % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      chk("t3_done_pulse", 64'(done), 64'h0);
    end
    req = 2'b00;
    tick();
    chk("t3_idle_gnt", 64'(gnt), 64'h0);

    // Reset while waiting on read data
    set_req(0, 1'b0, 10'h010, 32'h0, MASK_WORD);
    req[0] = 1'b1;
    tick();
    chk("t5_issue_gnt", 64'(gnt), 64'h1);
    tick();
    chk("t5_wait_gnt",  64'(gnt), 64'h1);
    reset = 1'b1;
    tick();
    chk_all_zero("t5_rst");
    reset = 1'b0;
    tick();
    chk("t5_re_gnt",    64'(gnt), 64'h1);
    chk("t5_re_rd_en",  64'(mem_rd_en), 64'h1);
    tick();
    chk("t5_re_wait",   64'(done), 64'h0);
    tick();
    chk("t5_re_done",   64'(done), 64'h1);
    chk("t5_re_rdata",  64'(rdata), 64'hDEAD_BEEF);
    req[0] = 1'b0;
    tick();
    chk("t5_idle_done", 64'(done), 64'h0);

`ifdef ARB_STATS_EN
    // Two more core0 transactions after the one counted since reset
    for (int n = 0; n < 2; n++) begin
      logic seen;
      seen = 1'b0;
      set_req(0, 1'b1, 10'h040, 32'h0000_0040, MASK_WORD);
      req[0] = 1'b1;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        if (done[0]) seen = 1'b1;
      end
      chk("t6_txn_done", 64'(seen), 64'h1);
      req[0] = 1'b0;
      tick();
    end
    chk("t6_cnt0", 64'(grant_cnt[15:0]), 64'd3);
    chk("t6_cnt1", 64'(grant_cnt[31:16]), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
